// File: rtl/unsigned_clz_divider.sv
// Multi-cycle unsigned divider. The divisor is pre-aligned with the dividend
// using the caller-supplied leading-zero counts, so only the quotient bits that
// can actually be set are iterated (one restoring step per cycle).
module unsigned_clz_divider #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         dividend,
    input  logic [$clog2(DATA_WIDTH)-1:0] dividend_CLZ,
    input  logic [DATA_WIDTH-1:0]         divisor,
    input  logic [$clog2(DATA_WIDTH)-1:0] divisor_CLZ,
    input  logic                          divisor_is_zero,
    output logic [DATA_WIDTH-1:0]         quotient,
    output logic [DATA_WIDTH-1:0]         remainder,
    output logic                          done
);

    localparam int unsigned CLZ_W = $clog2(DATA_WIDTH);
    // One extra bit so an iteration count of DATA_WIDTH is representable.
    localparam int unsigned CNT_W = CLZ_W + 1;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    logic                  state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] div_q, div_d;
    logic                  done_q, done_d;
    logic [CLZ_W-1:0]      shift;

    // Only meaningful when divisor <= dividend, which guarantees a non-negative difference.
    assign shift = divisor_CLZ - dividend_CLZ;

    // Next-state: accept/short-circuit in IDLE, one restoring step per RUN cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        div_d   = div_q;
        done_d  = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (start) begin
                    if (divisor_is_zero) begin
                        quot_d = '1;
                        rem_d  = dividend;
                        done_d = 1'b1;
                    end else if (divisor > dividend) begin
                        quot_d = '0;
                        rem_d  = dividend;
                        done_d = 1'b1;
                    end else begin
                        quot_d  = '0;
                        rem_d   = dividend;
                        div_d   = divisor << shift;
                        count_d = {1'b0, shift} + {{CLZ_W{1'b0}}, 1'b1};
                        state_d = STATE_RUN;
                    end
                end
            end
            STATE_RUN: begin
                if (rem_q >= div_q) begin
                    rem_d  = rem_q - div_q;
                    quot_d = {quot_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    quot_d = {quot_q[DATA_WIDTH-2:0], 1'b0};
                end
                div_d   = div_q >> 1;
                count_d = count_q - {{CLZ_W{1'b0}}, 1'b1};
                if (count_q == {{CLZ_W{1'b0}}, 1'b1}) begin
                    state_d = STATE_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // State registers with asynchronous clear; reset aborts any operation silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_IDLE;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: tb/tb_unsigned_clz_divider.sv
// Directed bench for unsigned_clz_divider: vector table plus hand-written
// sequences for start-during-RUN, mid-run reset and back-to-back operation.
module tb_unsigned_clz_divider;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [4:0]   dividend_CLZ;
    logic [W-1:0] divisor;
    logic [4:0]   divisor_CLZ;
    logic         divisor_is_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;

    int checks = 0;
    int errors = 0;

    unsigned_clz_divider #(.DATA_WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .dividend       (dividend),
        .dividend_CLZ   (dividend_CLZ),
        .divisor        (divisor),
        .divisor_CLZ    (divisor_CLZ),
        .divisor_is_zero(divisor_is_zero),
        .quotient       (quotient),
        .remainder      (remainder),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        int           exp_lat;
    } vec_t;

    vec_t vecs[10];

    // Leading-zero count saturating at 31 (zero operand).
    function automatic logic [4:0] clz(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return 5'(W - 1 - i);
        end
        return 5'd31;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend        = a;
        dividend_CLZ    = clz(a);
        divisor         = b;
        divisor_CLZ     = clz(b);
        divisor_is_zero = (b == '0);
        start           = 1'b1;
    endtask

    // Returns at the negedge of the done cycle; lat counts cycles after the start cycle.
    task automatic wait_done(output int lat);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;

    initial begin
        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,   6};
        vecs[1] = '{32'd123,        32'd0,          32'hFFFF_FFFF,  32'd123, 1};
        vecs[2] = '{32'd5,          32'd9,          32'd0,          32'd5,   1};
        vecs[3] = '{32'd0,          32'd3,          32'd0,          32'd0,   1};
        vecs[4] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   33};
        vecs[5] = '{32'd1000,       32'd10,         32'd100,        32'd0,   8};
        vecs[6] = '{32'd7,          32'd7,          32'd1,          32'd0,   2};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   2};
        vecs[8] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,   32};
        vecs[9] = '{32'd50,         32'd5,          32'd10,         32'd0,   5};

        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        dividend_CLZ = '0;
        divisor = '0;
        divisor_CLZ = '0;
        divisor_is_zero = 1'b0;
        repeat (3) @(negedge clk);
        check("reset quotient", quotient, '0);
        check("reset remainder", remainder, '0);
        check("reset done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d quotient", i), quotient, vecs[i].exp_q);
            check($sformatf("vec%0d remainder", i), remainder, vecs[i].exp_r);
            @(negedge clk);
            check($sformatf("vec%0d done one cycle", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d quotient held", i), quotient, vecs[i].exp_q);
            check($sformatf("vec%0d remainder held", i), remainder, vecs[i].exp_r);
        end

        // start held with other operands during RUN must be ignored.
        start_op(32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        start_op(32'd10, 32'd3);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 20) start = 1'b0;
        end
        check("held start latency", 32'(lat), 32'd33);
        check("held start quotient", quotient, 32'hFFFF_FFFF);
        check("held start remainder", remainder, 32'd0);
        @(negedge clk);

        // Reset in the middle of a RUN: outputs clear at once, no done afterwards.
        start_op(32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst quotient", quotient, '0);
        check("midrst remainder", remainder, '0);
        check("midrst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) lat++;
        end
        check("no done after abort", 32'(lat), 32'd0);
        start_op(32'd50, 32'd5);
        wait_done(lat);
        check("post-reset latency", 32'(lat), 32'd5);
        check("post-reset quotient", quotient, 32'd10);
        check("post-reset remainder", remainder, 32'd0);

        // Back-to-back: next start presented in the done cycle.
        @(negedge clk);
        start_op(32'd100, 32'd7);
        wait_done(lat);
        check("b2b first latency", 32'(lat), 32'd6);
        check("b2b first quotient", quotient, 32'd14);
        start_op(32'd9, 32'd3);
        wait_done(lat);
        check("b2b second latency", 32'(lat), 32'd4);
        check("b2b second quotient", quotient, 32'd3);
        check("b2b second remainder", remainder, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
